// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// Optional per-requester ack statistics when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                     wr_clk,
  input  logic                     areset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          last,
  input  logic [NREQ*DWIDTH-1:0]   data,
  output logic [NREQ-1:0]          ack,
  output logic [NREQ-1:0]          grant,
  input  logic                     fifo_full,
  output logic [DWIDTH-1:0]        fifo_datain,
  output logic                     fifo_write,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic [$clog2(NREQ)-1:0]  stat_sel,
  input  logic                     stat_clr,
  output logic [15:0]              stat_count
`endif
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam logic [7:0] CntLast = 8'(MAX_BURST - 1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              busy_q, busy_d;

  logic [IW-1:0]     gidx;
  logic [IW-1:0]     ptr_rel;
  logic [NREQ-1:0]   next_oh;
  logic              req_g, last_g, xfer, drop, rel;

  // First set candidate at or after start, searching upward with wrap.
  function automatic logic [NREQ-1:0] pick(input logic [NREQ-1:0] cand,
                                           input logic [IW-1:0]   start);
    logic [NREQ-1:0] oh;
    int idx;
    oh = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = (int'(start) + k) % int'(NREQ);
      if (oh == '0 && cand[idx]) oh[idx] = 1'b1;
    end
    return oh;
  endfunction

  always_comb begin
    gidx        = '0;
    fifo_datain = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant_q[i]) begin
        gidx        = IW'(i);
        fifo_datain = fifo_datain | data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign ack        = grant_q & req & {NREQ{~fifo_full}};
  assign fifo_write = |ack;
  assign grant      = grant_q;
  assign busy       = busy_q;

  assign req_g   = |(grant_q & req);
  assign last_g  = |(grant_q & last);
  assign xfer    = fifo_write;
  assign drop    = ~req_g;
  assign rel     = drop | (xfer & (last_g | (cnt_q == CntLast)));
  assign ptr_rel = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
  // A withdrawn requester is excluded so it cannot win its own handover.
  assign next_oh = pick(req & ~(drop ? grant_q : '0),
                        (state_q == StIdle) ? ptr_q : ptr_rel);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = next_oh;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (xfer) cnt_d = cnt_q + 8'd1;
        if (rel) begin
          ptr_d = ptr_rel;
          cnt_d = '0;
          if (|next_oh) begin
            grant_d = next_oh;
          end else begin
            grant_d = '0;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk or posedge areset) begin
    if (areset) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_q [NREQ];
  logic [15:0] stat_count_q;

  always_ff @(posedge wr_clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < int'(NREQ); i++) stat_q[i] <= '0;
      stat_count_q <= '0;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (stat_clr) stat_q[i] <= '0;
        else if (ack[i] && stat_q[i] != 16'hFFFF) stat_q[i] <= stat_q[i] + 16'd1;
      end
      stat_count_q <= (int'(stat_sel) < int'(NREQ)) ? stat_q[stat_sel] : '0;
    end
  end

  assign stat_count = stat_count_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed steps plus random traffic
// against a behavioural round-robin model.
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DWIDTH = 8;
  localparam int MAX_BURST = 16;

  logic                   wr_clk = 1'b0;
  logic                   areset;
  logic [NREQ-1:0]        req, last, ack, grant;
  logic [NREQ*DWIDTH-1:0] data;
  logic                   fifo_full, fifo_write, busy;
  logic [DWIDTH-1:0]      fifo_datain;
`ifdef FIFO_ARB_STATS_EN
  logic [1:0]             stat_sel;
  logic                   stat_clr;
  logic [15:0]            stat_count;
  int                     mstat [NREQ];
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST)) dut (
    .wr_clk      (wr_clk),
    .areset      (areset),
    .req         (req),
    .last        (last),
    .data        (data),
    .ack         (ack),
    .grant       (grant),
    .fifo_full   (fifo_full),
    .fifo_datain (fifo_datain),
    .fifo_write  (fifo_write),
    .busy        (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_sel    (stat_sel),
    .stat_clr    (stat_clr),
    .stat_count  (stat_count)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  int nvec = 0, nmis = 0;
  // Model: granted index (-1 = none), round-robin pointer, words in current burst.
  int m_g, m_ptr, m_cnt;
  int writes;
  logic [NREQ-1:0]   e_ack_last, s_grant;
  logic [DWIDTH-1:0] s_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int search(input logic [NREQ-1:0] cand, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (cand[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_g = -1; m_ptr = 0; m_cnt = 0;
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) mstat[i] = 0;
`endif
  endtask

  // Check outputs against the model mid-cycle, then advance the model one edge.
  task automatic tick();
    logic [NREQ-1:0]   eg, ea, cand;
    logic [DWIDTH-1:0] ed;
    int n_g, n_ptr, n_cnt;
    bit rel_c, rel;
    eg = '0;
    ed = '0;
    if (m_g >= 0) begin
      eg[m_g] = 1'b1;
      ed = data[m_g*DWIDTH +: DWIDTH];
    end
    ea = eg & req & {NREQ{~fifo_full}};
    #1;
    check("grant", grant, eg);
    check("busy", busy, m_g >= 0);
    check("ack", ack, ea);
    check("fifo_write", fifo_write, |ea);
    check("fifo_datain", fifo_datain, ed);
    if (fifo_write === 1'b1) writes++;
    s_grant = grant;
    s_din = fifo_datain;
    e_ack_last = ea;
    n_g = m_g; n_ptr = m_ptr; n_cnt = m_cnt;
    if (m_g < 0) begin
      n_g = search(req, m_ptr);
      n_cnt = 0;
    end else begin
      rel_c = !req[m_g];
      rel = rel_c || (ea != 0 && (last[m_g] || m_cnt == MAX_BURST - 1));
      if (ea != 0) n_cnt = m_cnt + 1;
      if (rel) begin
        n_ptr = (m_g + 1) % NREQ;
        cand = req;
        if (rel_c) cand[m_g] = 1'b0;
        n_g = search(cand, n_ptr);
        n_cnt = 0;
      end
    end
`ifdef FIFO_ARB_STATS_EN
    if (stat_clr) begin
      for (int i = 0; i < NREQ; i++) mstat[i] = 0;
    end else begin
      for (int i = 0; i < NREQ; i++) if (ea[i] && mstat[i] < 65535) mstat[i]++;
    end
`endif
    @(posedge wr_clk);
    m_g = n_g; m_ptr = n_ptr; m_cnt = n_cnt;
    #2;
  endtask

  task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic f);
    req = r; last = l; fifo_full = f;
    for (int i = 0; i < NREQ; i++) data[i*DWIDTH +: DWIDTH] = DWIDTH'($urandom);
    tick();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    req = '0; last = '0; fifo_full = 1'b0; data = '0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_write", fifo_write, 0);
    check("rst_datain", fifo_datain, 0);
    @(posedge wr_clk);
    #2;
    areset = 1'b0;
    model_reset();
  endtask

  initial begin
    int words;
    logic [NREQ-1:0] prevg, r, l;
`ifdef FIFO_ARB_STATS_EN
    stat_sel = '0;
    stat_clr = 1'b0;
`endif
    do_reset();

    // Single requester, three words, last on the third, first word A5.
    writes = 0;
    words = 0;
    for (int c = 0; c < 10 && words < 3; c++) begin
      req = 4'b0001; last = (words == 2) ? 4'b0001 : 4'b0000; fifo_full = 1'b0;
      for (int i = 0; i < NREQ; i++) data[i*DWIDTH +: DWIDTH] = DWIDTH'($urandom);
      if (words == 0) data[7:0] = 8'hA5;
      tick();
      if (e_ack_last[0]) begin
        if (words == 0) check("t1_first_word", s_din, 8'hA5);
        words++;
      end
    end
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    check("t1_writes", writes, 3);

    // All requesting, one word each: grant rotates with no gap.
    prevg = '0;
    for (int k = 0; k < 9; k++) begin
      cyc(4'b1111, 4'b1111, 1'b0);
      if (k >= 2) check("t2_rotate", s_grant, {prevg[NREQ-2:0], prevg[NREQ-1]});
      prevg = s_grant;
    end

    // Burst cap: 19 words over 20 cycles with zero-bubble re-grant, then share.
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    writes = 0;
    repeat (20) cyc(4'b0001, 4'b0000, 1'b0);
    check("t3_writes", writes, 19);
    repeat (20) cyc(4'b0011, 4'b0000, 1'b0);

    // FIFO full mid-burst.
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    repeat (3) cyc(4'b0001, 4'b0000, 1'b0);
    writes = 0;
    repeat (5) cyc(4'b0001, 4'b0000, 1'b1);
    check("t4_no_write_full", writes, 0);
    repeat (3) cyc(4'b0001, 4'b0000, 1'b0);

    // Requester 2 withdraws while 3 waits.
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    repeat (2) cyc(4'b0100, 4'b0000, 1'b0);
    repeat (2) cyc(4'b1100, 4'b0000, 1'b0);
    cyc(4'b1000, 4'b0000, 1'b0);
    cyc(4'b1000, 4'b0000, 1'b0);
    check("t5_handover", s_grant, 4'b1000);

    // Asynchronous reset mid-write.
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    repeat (2) cyc(4'b0100, 4'b0000, 1'b0);
    #1;
    check("t6_pre_grant", grant, 4'b0100);
    check("t6_pre_write", fifo_write, 1);
    areset = 1'b1;
    #1;
    check("t6_async_write", fifo_write, 0);
    check("t6_async_grant", grant, 0);
    check("t6_async_busy", busy, 0);
    @(posedge wr_clk);
    #2;
    areset = 1'b0;
    req = '0;
    model_reset();
`ifdef FIFO_ARB_STATS_EN
    for (int s = 0; s < NREQ; s++) begin
      stat_sel = 2'(s);
      cyc(4'b0000, 4'b0000, 1'b0);
      check("stat_after_reset", stat_count, 0);
    end
`endif

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      r = NREQ'($urandom);
      l = NREQ'($urandom) & NREQ'($urandom);
      cyc(r, l, $urandom_range(0, 4) == 0);
    end

`ifdef FIFO_ARB_STATS_EN
    for (int s = 0; s < NREQ; s++) begin
      stat_sel = 2'(s);
      cyc(4'b0000, 4'b0000, 1'b0);
      check("stat_count", stat_count, mstat[s]);
    end
    stat_clr = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b0);
    stat_clr = 1'b0;
    stat_sel = 2'd0;
    cyc(4'b0000, 4'b0000, 1'b0);
    check("stat_clr", stat_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of the asynchronous FIFO among NREQ requesters in the write-clock domain. It grants one requester at a time for a burst, muxes that requester's data onto the FIFO write port and stalls on FIFO full. A burst ends on a last-word marker, a burst-length cap, or when the requester withdraws.

Parameters:
NREQ, 4, number of requesters (2..8)
DWIDTH, 8, data width; matches the FIFO DWIDTH
MAX_BURST, 16, maximum words per grant before forced release (1..255)

Ports:
wr_clk  input  1  write-domain clock; all state on rising edge
areset  input  1  asynchronous active-high reset
req  input  NREQ  per-requester request; a requester holds it while it has data
last  input  NREQ  per-requester last-word marker, qualified by the word transfer
data  input  NREQ*DWIDTH  flattened requester data; requester i occupies bits [i*DWIDTH +: DWIDTH]
ack  output  NREQ  word accepted this cycle (combinational)
grant  output  NREQ  one-hot registered grant
fifo_full  input  1  full flag from the FIFO write side
fifo_datain  output  DWIDTH  to FIFO datain
fifo_write  output  1  to FIFO write
busy  output  1  registered; 1 while any grant is active

Behaviour:
- Reset (asynchronous, active-high):
  - grant=0, busy=0, burst counter=0, round-robin pointer=0, state=IDLE.
  - fifo_write, ack and fifo_datain=0 during reset, because they are derived from grant.
- Datapath (combinational):
  - ack[i] = grant[i] & req[i] & ~fifo_full.
  - fifo_write = |ack.
  - fifo_datain = data slice of the granted index; 0 when grant=0.
  - No data latency: the word is captured by the FIFO on the same wr_clk edge.
- States: IDLE, BURST.
- IDLE:
  - If req!=0, the winner is the first set req at or after the pointer, searching upward with wrap.
  - On the next edge: grant=onehot(winner), counter=0, state=BURST, busy=1.
  - If req=0, remain in IDLE.
- BURST, transfer (ack active): counter increments.
- BURST, release condition is any of:
  - (a) transfer with last[g]=1
  - (b) transfer with counter==MAX_BURST-1
  - (c) req[g]=0 with no transfer
- BURST, on release:
  - pointer = (g+1) mod NREQ.
  - The next winner is searched combinationally from the new pointer over the current req, excluding g in case (c).
  - If a winner exists, grant moves directly to it on the same edge with counter=0 (zero-bubble handover). Otherwise grant=0, busy=0, state=IDLE.
- fifo_full during BURST:
  - No ack, counter holds, grant holds indefinitely; there is no timeout.
  - Case (c) still releases if req drops while full.
- Single active requester: it may be re-granted immediately after release; fairness applies only among simultaneous requesters.
- Non-granted requesters never see ack; their data and last are ignored.
- Reset mid-burst: grant drops asynchronously, so no partial FIFO write occurs after areset rises. The burst is lost from the arbiter's view; requesters re-request.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined:
  - Adds input stat_sel (clog2(NREQ) bits), input stat_clr (1), and output stat_count (16).
  - Each requester has a 16-bit saturating counter (stops at 16'hFFFF) that increments on its ack.
  - stat_count is registered: it equals the counter of stat_sel one cycle after sampling.
  - stat_clr zeroes all counters synchronously and has priority over increment.
  - All counters reset to 0 on areset.
- Undefined: the three ports and the counters are absent; arbitration behaviour is identical.

Test Plan:
- Reset, then req=4'b0001 with data0=8'hA5 and last asserted on the 3rd word, fifo_full=0 -> grant=0001 one cycle after req; three fifo_write pulses, the first with fifo_datain=8'hA5; grant=0 and busy=0 after the 3rd word.
- req=4'b1111 held, last=1 on every word -> grants follow the sequence 0001, 0010, 0100, 1000, 0001 with no idle cycle between grants; one word each.
- MAX_BURST=16, req0 held with last=0 -> exactly 16 acks, then release; grant re-issued to requester 0 with counter restarted; with req1 also set, grant goes to requester 1 instead.
- fifo_full=1 for 5 cycles mid-burst -> fifo_write=0 and ack=0 throughout, counter frozen, grant unchanged; the burst resumes at the next word when full drops.
- req2 dropped mid-burst while req3=1 -> on the following edge grant=1000 with no write in the drop cycle.
- areset pulsed while grant=0100 and fifo_write=1 -> fifo_write, grant and busy go to 0 before the next wr_clk edge. With FIFO_ARB_STATS_EN: stat_count=0 for all selections after reset.
